decode_stage_fwd: RTL and testbench
===================================

// Module: decode_stage_fwd
// PURPOSE
//  Parametrised RV64/RV32 decode stage: reads operands from an external register file, forwards from N
//  younger pipeline stages, generates immediates, and latches results into the DE->EXE pipeline register.
//  Adds what the fixed-width decode lacks: valid/ready backpressure, flush, a load-use interlock with a
//  configurable bubble count, and a saturating stall counter. Sits between fetch and execute.
// PARAMETERS
//  XLEN              64  datapath width (32 or 64); immediates sign-extend to XLEN
//  NUM_FWD           2   forwarding sources; index 0 = youngest (EXE->MEM), highest priority
//  LOAD_USE_BUBBLES  1   bubbles inserted when the instruction in the EXE latch is a load feeding DE (1..3)
//  STALL_CNT_W       32  width of the stall performance counter
// PORTS
//  CLK          in   1               clock
//  RESET        in   1               synchronous, active-high reset
//  DE_V         in   1               DE instruction valid
//  DE_IR        in   32              DE instruction
//  DE_NPC       in   XLEN            DE next-PC
//  DE_READY     out  1               DE may advance this cycle (comb)
//  RS1_ADDR     out  5               regfile read address = DE_IR[19:15] (comb)
//  RS2_ADDR     out  5               regfile read address = DE_IR[24:20] (comb)
//  RF_RS1       in   XLEN            regfile read data 1 (same-cycle, write-through)
//  RF_RS2       in   XLEN            regfile read data 2
//  FWD_V        in   NUM_FWD         forwarding source i valid and writes rd
//  FWD_RD       in   5*NUM_FWD       source i rd, packed [5*i+:5]
//  FWD_DATA     in   XLEN*NUM_FWD    source i result, packed [XLEN*i+:XLEN]
//  FLUSH        in   1               kill DE and EXE latch contents (branch/trap redirect)
//  EXE_READY    in   1               execute accepts a new latch value
//  EXE_V        out  1               EXE latch valid
//  EXE_IR       out  32              latched instruction
//  EXE_NPC      out  XLEN            latched next-PC
//  EXE_OP1      out  XLEN            forwarded rs1 value
//  EXE_OP2      out  XLEN            forwarded rs2 value, or immediate when DE_IR[5]==0
//  EXE_RS2      out  XLEN            forwarded rs2 value always (store data)
//  EXE_IMM      out  XLEN            decoded immediate
//  STALL_CNT    out  STALL_CNT_W     cycles with DE_V & ~DE_READY, saturating
// BEHAVIOUR
//  - Reset: all EXE_* outputs 0, EXE_V=0, bubble counter 0, STALL_CNT 0.
//  - Immediates: I (OP-IMM, LOAD, JALR), S, B, U (LUI/AUIPC), J (JAL), sign-extended to XLEN; shift-imm
//    takes $clog2(XLEN) bits of IR[25:20] zero-extended; OP-IMM-32 shifts take IR[24:20].
//  - Source use: rs1 used except LUI/AUIPC/JAL; rs2 used for OP, OP-32, STORE, BRANCH only.
//  - Forward: for each rs, lowest index i with FWD_V[i] & FWD_RD[i]==rs & rs!=0 wins; else RF data.
//    rs==0 always yields 0.
//  - Load-use: hz_start = DE_V & EXE_V & EXE_IR[6:0]==LOAD & EXE_IR[11:7]!=0 & EXE_IR[11:7] matches a
//    used rs. When hz_start or bub_cnt!=0: DE_READY=0; on EXE_READY, EXE_V<=0 (bubble).
//    On hz_start & EXE_READY, bub_cnt<=LOAD_USE_BUBBLES-1; else bub_cnt decrements on EXE_READY while >0.
//  - DE_READY = EXE_READY & ~hz_start & (bub_cnt==0).
//  - Latch update on EXE_READY: if DE_READY, latch DE fields and EXE_V<=DE_V; else bubble.
//    ~EXE_READY holds all EXE_* outputs.
//  - FLUSH (priority below RESET, above all else): EXE_V<=0 and bub_cnt<=0 regardless of EXE_READY;
//    DE_READY=1 that cycle.
//  - STALL_CNT += 1 when DE_V & ~DE_READY & ~FLUSH; holds at all-ones.
//  - Latency: one cycle DE->EXE when not stalled.
// STRUCTURE
//  - Shared package rv_pkg: opcode localparams (OP, OP_IMM, OP_32, OP_IMM_32, LOAD, STORE, BRANCH,
//    LUI, AUIPC, JAL, JALR, SYSTEM) and imm-type enum.
//  - Sub-module imm_gen #(XLEN) (pure combinational, IR->imm).
//  - Forward muxes are a generate loop in this module.
// TESTING
//  1. ADDI x5,x0,-1 (0xFFF00293), XLEN=64, no hazards -> next cycle EXE_V=1, EXE_OP2=0xFFFF_FFFF_FFFF_FFFF.
//  2. ADD x3,x1,x2 with FWD_V=2'b11, both FWD_RD=1, FWD_DATA0=0xA, FWD_DATA1=0xB, RF_RS2=7
//     -> EXE_OP1=0xA, EXE_OP2=7.
//  3. LD x4 in EXE latch, DE=ADD x6,x4,x4, LOAD_USE_BUBBLES=2
//     -> DE_READY=0 two cycles, two EXE_V=0 bubbles, ADD latched on third cycle, STALL_CNT=2.
//  4. Rs=x0 with FWD_RD0=0, FWD_DATA0=0x55 -> EXE_OP1=0.
//  5. EXE_READY=0 for 3 cycles mid-stream -> EXE_* held unchanged; then FLUSH mid-bubble
//     -> EXE_V=0, bub_cnt=0, DE_READY=1.
//  6. RESET asserted during load-use stall -> all outputs 0 next cycle, STALL_CNT=0.

Source files
------------

// File: rtl/decode_stage_fwd_pkg.sv
// RV opcode map, immediate-format classes and operand-use helpers shared by the decode slice.
package decode_stage_fwd_pkg;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_SHAMT,
    IMM_SHAMTW,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_t;

  // funct3 001/101 are the shift encodings inside OP-IMM and OP-IMM-32
  function automatic imm_type_t imm_type_of(input logic [6:0] opc, input logic [2:0] funct3);
    imm_type_t t;
    t = IMM_NONE;
    case (opc)
      OPC_OP_IMM:          t = (funct3[1:0] == 2'b01) ? IMM_SHAMT : IMM_I;
      OPC_OP_IMM_32:       t = (funct3[1:0] == 2'b01) ? IMM_SHAMTW : IMM_I;
      OPC_LOAD, OPC_JALR:  t = IMM_I;
      OPC_STORE:           t = IMM_S;
      OPC_BRANCH:          t = IMM_B;
      OPC_LUI, OPC_AUIPC:  t = IMM_U;
      OPC_JAL:             t = IMM_J;
      default:             t = IMM_NONE;
    endcase
    return t;
  endfunction

  function automatic logic uses_rs1(input logic [6:0] opc);
    return !(opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    return opc inside {OPC_OP, OPC_OP_32, OPC_STORE, OPC_BRANCH};
  endfunction

endpackage

// File: rtl/decode_stage_fwd_if.sv
// Fetch/regfile/forwarding/execute signal bundle around the decode stage; slave = decode stage.
interface decode_stage_fwd_if #(
  parameter int XLEN        = 64,
  parameter int NUM_FWD     = 2,
  parameter int STALL_CNT_W = 32
);
  logic                     DE_V;
  logic [31:0]              DE_IR;
  logic [XLEN-1:0]          DE_NPC;
  logic                     DE_READY;
  logic [4:0]               RS1_ADDR;
  logic [4:0]               RS2_ADDR;
  logic [XLEN-1:0]          RF_RS1;
  logic [XLEN-1:0]          RF_RS2;
  logic [NUM_FWD-1:0]       FWD_V;
  logic [5*NUM_FWD-1:0]     FWD_RD;
  logic [XLEN*NUM_FWD-1:0]  FWD_DATA;
  logic                     FLUSH;
  logic                     EXE_READY;
  logic                     EXE_V;
  logic [31:0]              EXE_IR;
  logic [XLEN-1:0]          EXE_NPC;
  logic [XLEN-1:0]          EXE_OP1;
  logic [XLEN-1:0]          EXE_OP2;
  logic [XLEN-1:0]          EXE_RS2;
  logic [XLEN-1:0]          EXE_IMM;
  logic [STALL_CNT_W-1:0]   STALL_CNT;

  modport master (
    output DE_V, DE_IR, DE_NPC, RF_RS1, RF_RS2, FWD_V, FWD_RD, FWD_DATA, FLUSH, EXE_READY,
    input  DE_READY, RS1_ADDR, RS2_ADDR, EXE_V, EXE_IR, EXE_NPC, EXE_OP1, EXE_OP2, EXE_RS2,
           EXE_IMM, STALL_CNT
  );

  modport slave (
    input  DE_V, DE_IR, DE_NPC, RF_RS1, RF_RS2, FWD_V, FWD_RD, FWD_DATA, FLUSH, EXE_READY,
    output DE_READY, RS1_ADDR, RS2_ADDR, EXE_V, EXE_IR, EXE_NPC, EXE_OP1, EXE_OP2, EXE_RS2,
           EXE_IMM, STALL_CNT
  );
endinterface

// File: rtl/decode_stage_fwd_imm_gen.sv
// Combinational immediate decoder: IR -> XLEN immediate, sign-extended except shift amounts.
module decode_stage_fwd_imm_gen
  import decode_stage_fwd_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     ir,
  output logic [XLEN-1:0] imm
);

  localparam int SHW = $clog2(XLEN);

  imm_type_t          ty;
  logic signed [31:0] simm;

  assign ty = imm_type_of(ir[6:0], ir[14:12]);

  always_comb begin
    simm = '0;
    case (ty)
      IMM_I:   simm = 32'($signed(ir[31:20]));
      IMM_S:   simm = 32'($signed({ir[31:25], ir[11:7]}));
      IMM_B:   simm = 32'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
      IMM_U:   simm = {ir[31:12], 12'h000};
      IMM_J:   simm = 32'($signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));
      default: simm = '0;
    endcase

    // simm is signed, so the width cast replicates bit 31 up to XLEN
    if (ty == IMM_SHAMT) begin
      imm = XLEN'(ir[20 +: SHW]);
    end else if (ty == IMM_SHAMTW) begin
      imm = XLEN'(ir[24:20]);
    end else begin
      imm = XLEN'(simm);
    end
  end

endmodule

// File: rtl/decode_stage_fwd.sv
// Decode stage: operand read + forwarding + imm gen into the DE->EXE latch, one cycle when not stalled.
// DE_READY drops on EXE backpressure or load-use interlock; FLUSH kills the latch and accepts DE.
module decode_stage_fwd
  import decode_stage_fwd_pkg::*;
#(
  parameter int XLEN             = 64,
  parameter int NUM_FWD          = 2,
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int STALL_CNT_W      = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  decode_stage_fwd_if.slave bus
);

  typedef struct packed {
    logic            v;
    logic [31:0]     ir;
    logic [XLEN-1:0] npc;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] imm;
  } exe_t;

  localparam logic [1:0] BUB_INIT = 2'(LOAD_USE_BUBBLES - 1);

  logic [6:0]             de_opc;
  logic [4:0]             rs1;
  logic [4:0]             rs2;
  logic                   rs1_use;
  logic                   rs2_use;
  logic [XLEN-1:0]        imm;
  logic [XLEN-1:0]        op1;
  logic [XLEN-1:0]        op2;
  logic [NUM_FWD-1:0]     hit1;
  logic [NUM_FWD-1:0]     hit2;
  logic [4:0]             exe_rd;
  logic                   hz_start;
  logic                   de_ready;
  exe_t                   exe_q;
  logic [1:0]             bub_cnt;
  logic [STALL_CNT_W-1:0] stall_cnt;

  assign de_opc  = bus.DE_IR[6:0];
  assign rs1     = bus.DE_IR[19:15];
  assign rs2     = bus.DE_IR[24:20];
  assign rs1_use = uses_rs1(de_opc);
  assign rs2_use = uses_rs2(de_opc);

  decode_stage_fwd_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .ir  (bus.DE_IR),
    .imm (imm)
  );

  for (genvar i = 0; i < NUM_FWD; i++) begin : g_fwd
    assign hit1[i] = bus.FWD_V[i] && (bus.FWD_RD[5*i +: 5] == rs1);
    assign hit2[i] = bus.FWD_V[i] && (bus.FWD_RD[5*i +: 5] == rs2);
  end

  // Walk oldest to youngest so the lowest matching index is the last writer
  always_comb begin
    op1 = bus.RF_RS1;
    op2 = bus.RF_RS2;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (hit1[i]) op1 = bus.FWD_DATA[XLEN*i +: XLEN];
      if (hit2[i]) op2 = bus.FWD_DATA[XLEN*i +: XLEN];
    end
    if (rs1 == 5'd0) op1 = '0;
    if (rs2 == 5'd0) op2 = '0;
  end

  assign exe_rd   = exe_q.ir[11:7];
  assign hz_start = bus.DE_V && exe_q.v && (exe_q.ir[6:0] == OPC_LOAD) && (exe_rd != 5'd0) &&
                    ((rs1_use && (rs1 == exe_rd)) || (rs2_use && (rs2 == exe_rd)));
  assign de_ready = bus.FLUSH || (bus.EXE_READY && !hz_start && (bub_cnt == 2'd0));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      exe_q     <= '0;
      bub_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (bus.FLUSH) begin
        exe_q.v <= 1'b0;
        bub_cnt <= '0;
      end else if (bus.EXE_READY) begin
        if (de_ready) begin
          exe_q.v   <= bus.DE_V;
          exe_q.ir  <= bus.DE_IR;
          exe_q.npc <= bus.DE_NPC;
          exe_q.op1 <= op1;
          exe_q.op2 <= bus.DE_IR[5] ? op2 : imm;
          exe_q.rs2 <= op2;
          exe_q.imm <= imm;
        end else begin
          exe_q.v <= 1'b0;
        end
        if (hz_start) begin
          bub_cnt <= BUB_INIT;
        end else if (bub_cnt != 2'd0) begin
          bub_cnt <= bub_cnt - 2'd1;
        end
      end

      if (bus.DE_V && !de_ready && !bus.FLUSH && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + STALL_CNT_W'(1);
      end
    end
  end

  assign bus.DE_READY  = de_ready;
  assign bus.RS1_ADDR  = rs1;
  assign bus.RS2_ADDR  = rs2;
  assign bus.EXE_V     = exe_q.v;
  assign bus.EXE_IR    = exe_q.ir;
  assign bus.EXE_NPC   = exe_q.npc;
  assign bus.EXE_OP1   = exe_q.op1;
  assign bus.EXE_OP2   = exe_q.op2;
  assign bus.EXE_RS2   = exe_q.rs2;
  assign bus.EXE_IMM   = exe_q.imm;
  assign bus.STALL_CNT = stall_cnt;

endmodule

// File: tb/tb_decode_stage_fwd.sv
// Directed and randomized checks of decode_stage_fwd against a behavioural model.
module tb_decode_stage_fwd;

  localparam int XLEN = 64;
  localparam int NF   = 2;
  localparam int LUB  = 2;
  localparam int SCW  = 4;

  localparam logic [31:0] I_ADDI = 32'hFFF00293;  // addi x5,x0,-1
  localparam logic [31:0] I_ADD3 = 32'h002081B3;  // add  x3,x1,x2
  localparam logic [31:0] I_ADD7 = 32'h002003B3;  // add  x7,x0,x2
  localparam logic [31:0] I_LD4  = 32'h0000B203;  // ld   x4,0(x1)
  localparam logic [31:0] I_ADD6 = 32'h00420333;  // add  x6,x4,x4

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  decode_stage_fwd_if #(.XLEN(XLEN), .NUM_FWD(NF), .STALL_CNT_W(SCW)) bus ();

  decode_stage_fwd #(
    .XLEN(XLEN), .NUM_FWD(NF), .LOAD_USE_BUBBLES(LUB), .STALL_CNT_W(SCW)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  logic [6:0] opcs [12] = '{7'h33, 7'h3b, 7'h13, 7'h1b, 7'h03, 7'h03,
                            7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h67};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_de(input logic v, input logic [31:0] ir, input logic [63:0] npc);
    bus.DE_V   = v;
    bus.DE_IR  = ir;
    bus.DE_NPC = npc;
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Immediate straight from the ISA field layouts
  function automatic logic [63:0] ref_imm(input logic [31:0] ir);
    longint v;
    logic [2:0] f3;
    f3 = ir[14:12];
    v  = 0;
    case (ir[6:0])
      7'h13: if (f3 == 3'd1 || f3 == 3'd5) v = ir[25:20]; else v = $signed(ir[31:20]);
      7'h1b: if (f3 == 3'd1 || f3 == 3'd5) v = ir[24:20]; else v = $signed(ir[31:20]);
      7'h03, 7'h67: v = $signed(ir[31:20]);
      7'h23: v = $signed({ir[31:25], ir[11:7]});
      7'h63: v = $signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0});
      7'h37, 7'h17: v = $signed({ir[31:12], 12'h000});
      7'h6f: v = $signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0});
      default: v = 0;
    endcase
    return v;
  endfunction

  function automatic logic [63:0] ref_operand(input logic [4:0] rs, input logic [63:0] rf,
                                              input logic [1:0] fv, input logic [9:0] frd,
                                              input logic [127:0] fd);
    if (rs == 5'd0) return 64'd0;
    for (int i = 0; i < NF; i++) begin
      if (fv[i] && frd[5*i +: 5] == rs) return fd[64*i +: 64];
    end
    return rf;
  endfunction

  // Model state for the randomized run
  logic        m_v;
  logic [31:0] m_ir;
  logic [63:0] m_npc, m_op1, m_op2, m_rs2, m_imm;
  int          m_owed;
  int          m_cnt;

  initial begin
    logic        hold;
    logic        haz, exp_rdy, u1, u2;
    logic [6:0]  opc;
    logic [4:0]  r1, r2, lrd;
    logic [31:0] ir;

    rst = 1'b1;
    set_de(1'b0, 32'h0, 64'h0);
    bus.RF_RS1 = '0; bus.RF_RS2 = '0;
    bus.FWD_V = '0; bus.FWD_RD = '0; bus.FWD_DATA = '0;
    bus.FLUSH = 1'b0; bus.EXE_READY = 1'b1;
    tick(); tick();

    check("rst_exe_v", bus.EXE_V, 0);
    check("rst_exe_ir", bus.EXE_IR, 0);
    check("rst_exe_op2", bus.EXE_OP2, 0);
    check("rst_stall", bus.STALL_CNT, 0);
    rst = 1'b0;

    // ADDI x5,x0,-1: immediate fills OP2
    set_de(1'b1, I_ADDI, 64'h1004);
    bus.RF_RS1 = 64'h77;
    #1 check("addi_ready", bus.DE_READY, 1);
    tick();
    check("addi_v", bus.EXE_V, 1);
    check("addi_op2", bus.EXE_OP2, 64'hFFFF_FFFF_FFFF_FFFF);
    check("addi_imm", bus.EXE_IMM, 64'hFFFF_FFFF_FFFF_FFFF);
    check("addi_op1_x0", bus.EXE_OP1, 0);
    check("addi_npc", bus.EXE_NPC, 64'h1004);

    // ADD x3,x1,x2: both sources hit x1, index 0 wins
    set_de(1'b1, I_ADD3, 64'h1008);
    bus.FWD_V = 2'b11; bus.FWD_RD = {5'd1, 5'd1};
    bus.FWD_DATA = {64'hB, 64'hA};
    bus.RF_RS1 = 64'h99; bus.RF_RS2 = 64'h7;
    #1;
    check("add_rs1_addr", bus.RS1_ADDR, 1);
    check("add_rs2_addr", bus.RS2_ADDR, 2);
    tick();
    check("add_op1_fwd0", bus.EXE_OP1, 64'hA);
    check("add_op2_rf", bus.EXE_OP2, 64'h7);
    check("add_rs2", bus.EXE_RS2, 64'h7);

    // rs1 = x0 must ignore a forward targeting x0
    set_de(1'b1, I_ADD7, 64'h100C);
    bus.FWD_V = 2'b01; bus.FWD_RD = {5'd9, 5'd0};
    bus.FWD_DATA = {64'h0, 64'h55};
    bus.RF_RS1 = 64'h1234;
    tick();
    check("x0_op1", bus.EXE_OP1, 0);
    check("x0_op2", bus.EXE_OP2, 64'h7);

    // Load-use with two bubbles
    bus.FWD_V = 2'b00;
    bus.RF_RS1 = 64'h1111;
    set_de(1'b1, I_LD4, 64'h1010);
    tick();
    check("ld_latched", bus.EXE_IR, I_LD4);
    set_de(1'b1, I_ADD6, 64'h1014);
    #1 check("lu_ready_c0", bus.DE_READY, 0);
    tick();
    check("lu_bubble_c0", bus.EXE_V, 0);
    check("lu_stall_c0", bus.STALL_CNT, 1);
    check("lu_ready_c1", bus.DE_READY, 0);
    tick();
    check("lu_bubble_c1", bus.EXE_V, 0);
    check("lu_ready_c2", bus.DE_READY, 1);
    tick();
    check("lu_add_v", bus.EXE_V, 1);
    check("lu_add_ir", bus.EXE_IR, I_ADD6);
    check("lu_stall_total", bus.STALL_CNT, 2);

    // Execute backpressure holds the latch
    set_de(1'b1, I_ADDI, 64'h1018);
    bus.EXE_READY = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 check("hold_ready", bus.DE_READY, 0);
      tick();
      check("hold_ir", bus.EXE_IR, I_ADD6);
      check("hold_v", bus.EXE_V, 1);
      check("hold_op1", bus.EXE_OP1, 64'h1111);
    end
    check("hold_stall", bus.STALL_CNT, 5);

    // Flush in the middle of a load-use bubble
    bus.EXE_READY = 1'b1;
    set_de(1'b1, I_LD4, 64'h101C);
    tick();
    set_de(1'b1, I_ADD6, 64'h1020);
    tick();
    check("fl_bubble", bus.EXE_V, 0);
    bus.FLUSH = 1'b1;
    #1 check("fl_ready", bus.DE_READY, 1);
    tick();
    check("fl_exe_v", bus.EXE_V, 0);
    check("fl_stall", bus.STALL_CNT, 6);
    bus.FLUSH = 1'b0;
    #1 check("fl_bub_cleared", bus.DE_READY, 1);
    tick();
    check("fl_after_ir", bus.EXE_IR, I_ADD6);

    // Reset in a load-use stall
    set_de(1'b1, I_LD4, 64'h1024);
    tick();
    set_de(1'b1, I_ADD6, 64'h1028);
    tick();
    check("rs_stalled", bus.STALL_CNT, 7);
    rst = 1'b1;
    tick();
    check("rs_exe_v", bus.EXE_V, 0);
    check("rs_exe_ir", bus.EXE_IR, 0);
    check("rs_exe_npc", bus.EXE_NPC, 0);
    check("rs_exe_op1", bus.EXE_OP1, 0);
    check("rs_exe_imm", bus.EXE_IMM, 0);
    check("rs_stall", bus.STALL_CNT, 0);
    rst = 1'b0;
    #1 check("rs_ready", bus.DE_READY, 1);

    // Stall counter saturates at all-ones
    bus.EXE_READY = 1'b0;
    repeat (15) tick();
    check("sat_reach", bus.STALL_CNT, 15);
    repeat (3) tick();
    check("sat_hold", bus.STALL_CNT, 15);

    // Randomized run against the behavioural model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_v = 0; m_ir = 0; m_npc = 0; m_op1 = 0; m_op2 = 0; m_rs2 = 0; m_imm = 0;
    m_owed = 0; m_cnt = 0;
    hold = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!hold) begin
        ir = $urandom;
        ir[6:0]   = opcs[$urandom_range(0, 11)];
        ir[11:7]  = 5'($urandom_range(0, 3));
        ir[19:15] = 5'($urandom_range(0, 3));
        ir[24:20] = 5'($urandom_range(0, 3));
        set_de($urandom_range(0, 3) != 0, ir, rand64());
      end
      bus.RF_RS1 = rand64(); bus.RF_RS2 = rand64();
      bus.FWD_V = 2'($urandom_range(0, 3));
      bus.FWD_RD = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      bus.FWD_DATA = {rand64(), rand64()};
      bus.EXE_READY = ($urandom_range(0, 4) != 0);
      bus.FLUSH = ($urandom_range(0, 19) == 0);
      #1;

      opc = bus.DE_IR[6:0];
      r1 = bus.DE_IR[19:15];
      r2 = bus.DE_IR[24:20];
      lrd = m_ir[11:7];
      u1 = !(opc inside {7'h37, 7'h17, 7'h6f});
      u2 = opc inside {7'h33, 7'h3b, 7'h23, 7'h63};
      haz = bus.DE_V && m_v && m_ir[6:0] == 7'h03 && lrd != 0 &&
            ((u1 && r1 == lrd) || (u2 && r2 == lrd));
      exp_rdy = bus.FLUSH || (bus.EXE_READY && !haz && m_owed == 0);
      check("rnd_ready", bus.DE_READY, exp_rdy);
      check("rnd_rs2_addr", bus.RS2_ADDR, r2);

      if (bus.FLUSH) begin
        m_v = 0;
        m_owed = 0;
      end else if (bus.EXE_READY) begin
        if (exp_rdy) begin
          m_v   = bus.DE_V;
          m_ir  = bus.DE_IR;
          m_npc = bus.DE_NPC;
          m_op1 = ref_operand(r1, bus.RF_RS1, bus.FWD_V, bus.FWD_RD, bus.FWD_DATA);
          m_rs2 = ref_operand(r2, bus.RF_RS2, bus.FWD_V, bus.FWD_RD, bus.FWD_DATA);
          m_imm = ref_imm(bus.DE_IR);
          m_op2 = bus.DE_IR[5] ? m_rs2 : m_imm;
        end else begin
          m_v = 0;
        end
        if (haz) m_owed = LUB - 1;
        else if (m_owed > 0) m_owed--;
      end
      if (bus.DE_V && !exp_rdy && m_cnt < 15) m_cnt++;
      hold = bus.DE_V && !exp_rdy;

      tick();
      check("rnd_exe_v", bus.EXE_V, m_v);
      check("rnd_exe_ir", bus.EXE_IR, m_ir);
      check("rnd_exe_npc", bus.EXE_NPC, m_npc);
      check("rnd_exe_op1", bus.EXE_OP1, m_op1);
      check("rnd_exe_op2", bus.EXE_OP2, m_op2);
      check("rnd_exe_rs2", bus.EXE_RS2, m_rs2);
      check("rnd_exe_imm", bus.EXE_IMM, m_imm);
      check("rnd_stall", bus.STALL_CNT, m_cnt);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
